// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ requesters.
// Outputs are registered on posedge so they are stable before the negedge register-file capture.
module regfile_write_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               freeze,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr_flat,
  input  logic [NREQ*DW-1:0] data_flat,
  output logic               we,
  output logic [AW-1:0]      waddr,
  output logic [DW-1:0]      wdata,
  output logic [NREQ-1:0]    gnt,
  output logic               idle
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [NREQ-1:0] elig;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx;
  logic            found;
  logic [AW-1:0]   win_addr;

  // gnt_q doubles as last_gnt: both are cleared on freeze/no-winner and set to onehot(w) on a grant.
  always_comb begin
    elig  = req & ~gnt_q;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = ptr_q + PW'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_addr = addr_flat[int'(win)*AW +: AW];
  end

  always_comb begin
    ptr_d   = ptr_q;
    gnt_d   = '0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (!freeze && found) begin
      gnt_d[win] = 1'b1;
      waddr_d    = win_addr;
      wdata_d    = data_flat[int'(win)*DW +: DW];
      we_d       = (win_addr != '0);
      ptr_d      = win + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ptr_q   <= '0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign gnt   = gnt_q;
  assign idle  = (req == '0) && !we_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a reference model predicts each posedge result,
// a negedge monitor pops and compares.
module tb_regfile_write_arbiter;

  logic         clk = 1'b0;
  logic         clrn = 1'b0;
  logic         freeze = 1'b0;
  logic [3:0]   req = '0;
  logic [4:0]   addr [4];
  logic [31:0]  data [4];
  logic [19:0]  addr_flat;
  logic [127:0] data_flat;
  logic         we;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic [3:0]   gnt;
  logic         idle;

  assign addr_flat = {addr[3], addr[2], addr[1], addr[0]};
  assign data_flat = {data[3], data[2], data[1], data[0]};

  regfile_write_arbiter #(.NREQ(4), .AW(5), .DW(32)) dut (
    .clk(clk), .clrn(clrn), .freeze(freeze), .req(req),
    .addr_flat(addr_flat), .data_flat(data_flat),
    .we(we), .waddr(waddr), .wdata(wdata), .gnt(gnt), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  gnt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  // reference model state
  int          m_ptr  = 0;
  int          m_last = -1;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;

  logic [3:0] pending_drop = '0;
  logic [3:0] hold = '0;
  bit         rnd_en = 1'b0;
  logic [3:0] last_pushed_gnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_last = -1; m_waddr = '0; m_wdata = '0;
    pending_drop = '0;
  endtask

  // Predict what the arbiter registers at this posedge from the inputs it sees.
  task automatic model_edge();
    exp_t e;
    int w;
    w = -1;
    e.gnt = '0;
    e.we  = 1'b0;
    if (!freeze) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (w < 0 && req[j] && j != m_last) w = j;
      end
    end
    if (w >= 0) begin
      e.gnt   = 4'(1 << w);
      m_waddr = addr[w];
      m_wdata = data[w];
      e.we    = (addr[w] != 5'd0);
      m_ptr   = (w + 1) % 4;
      m_last  = w;
    end else begin
      m_last = -1;
    end
    e.waddr = m_waddr;
    e.wdata = m_wdata;
    last_pushed_gnt = e.gnt;
    sbq.push_back(e);
  endtask

  // One clock: model the edge, then (off the edge) apply the requester handshake.
  task automatic step();
    @(posedge clk);
    if (mon_en) model_edge();
    #1;
    req = req & ~(pending_drop & ~hold);
    pending_drop = last_pushed_gnt;
    last_pushed_gnt = '0;
    if (rnd_en) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          addr[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
          data[i] = $urandom;
          req[i]  = 1'b1;
        end
      end
      freeze = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    addr[i] = a; data[i] = d; req[i] = 1'b1;
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (mon_en) begin
      if (sbq.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        me = sbq.pop_front();
        chk("gnt",   32'(gnt),   32'(me.gnt));
        chk("we",    32'(we),    32'(me.we));
        chk("waddr", 32'(waddr), 32'(me.waddr));
        chk("wdata", wdata,      me.wdata);
        chk("idle",  32'(idle),  32'((req == 4'd0) && !me.we));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin addr[i] = '0; data[i] = '0; end
    #12;
    @(negedge clk); #1;
    clrn = 1'b1; model_reset(); mon_en = 1'b1;

    // Load outputs with non-zero values, then reset asynchronously mid-cycle.
    for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'hA0 + 32'(i));
    step(); step();
    #2;
    mon_en = 1'b0;
    clrn = 1'b0;
    #1;
    sbq.delete();
    chk("rst_we",    32'(we),    32'd0);
    chk("rst_gnt",   32'(gnt),   32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", wdata,      32'd0);
    @(negedge clk); #1;
    model_reset();
    clrn = 1'b1;
    req = '0;
    for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'hA0 + 32'(i));
    mon_en = 1'b1;

    // All four request together: expect 0,1,2,3 then idle.
    repeat (7) step();

    // Round-robin wrap: grant 2, then 1011 -> 3,0,1.
    set_req(2, 5'd10, 32'h1234_5678);
    step(); step();
    set_req(0, 5'd11, 32'hB0); set_req(1, 5'd12, 32'hB1); set_req(3, 5'd13, 32'hB3);
    repeat (6) step();

    // Continuous single requester is masked every other cycle.
    hold = 4'b0010;
    set_req(1, 5'd7, 32'h55);
    repeat (6) step();
    hold = '0;
    repeat (3) step();

    // Address zero acks without writing.
    set_req(0, 5'd0, 32'hFFFF_FFFF);
    repeat (3) step();

    // Freeze holds off grants and the pointer.
    set_req(2, 5'd9, 32'hC0DE);
    freeze = 1'b1;
    repeat (3) step();
    freeze = 1'b0;
    repeat (3) step();

    // Randomized traffic with occasional freeze.
    rnd_en = 1'b1;
    repeat (400) step();
    rnd_en = 1'b0;
    freeze = 1'b0;
    repeat (8) step();

    @(negedge clk); #1;
    mon_en = 1'b0;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
